// File: rtl/onehot_scan_decoder.sv
// One-hot scan decoder.
// Drives a registered one-hot word where code k lights bit OUT_W-1-k.
// Direct mode decodes a handshaked select code. Scan mode steps through
// codes 0..scan_last, holding each one for DWELL cycles, and pulses wrap
// when the scan returns to code 0.
module onehot_scan_decoder #(
    parameter  int SEL_W = 4,
    parameter  int DWELL = 4,
    localparam int OUT_W = 2**SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    input  logic             sel_valid,
    output logic             sel_ready,
    input  logic [SEL_W-1:0] scan_last,
    output logic [OUT_W-1:0] out,
    output logic             out_valid,
    output logic [SEL_W-1:0] cur_code,
    output logic             wrap
);

    // A single-cycle dwell still needs a one-bit counter, so that the
    // DWELL-1 compare remains well formed.
    localparam int               DW_W      = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0]  DWELL_MAX = DW_W'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE,
        DIRECT,
        SCAN
    } state_t;

    state_t            state, state_nxt;
    logic [DW_W-1:0]   dwell, dwell_nxt;
    logic [OUT_W-1:0]  out_nxt;
    logic              vld_nxt;
    logic [SEL_W-1:0]  code_nxt;
    logic              wrap_nxt;

    // Code 0 maps to the MSB, and the highest code maps to the LSB.
    function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] k);
        logic [OUT_W-1:0] d;
        for (int i = 0; i < OUT_W; i++) begin
            d[i] = ((OUT_W - 1 - i) == int'(k));
        end
        return d;
    endfunction

    // A new select code is accepted only outside scan mode, and only while the block is enabled.
    always_comb begin
        sel_ready = en & ~mode & (state != SCAN);
    end

    // Compute the next state and the next registered outputs.
    always_comb begin
        state_nxt = state;
        dwell_nxt = dwell;
        vld_nxt   = out_valid;
        code_nxt  = cur_code;
        wrap_nxt  = 1'b0;

        if (!en) begin
            state_nxt = IDLE;
            vld_nxt   = 1'b0;
            code_nxt  = '0;
            dwell_nxt = '0;
        end else begin
            case (state)
                IDLE, DIRECT: begin
                    if (mode) begin
                        state_nxt = SCAN;
                        vld_nxt   = 1'b1;
                        code_nxt  = '0;
                        dwell_nxt = '0;
                    end else if (sel_valid && sel_ready) begin
                        state_nxt = DIRECT;
                        vld_nxt   = 1'b1;
                        code_nxt  = sel;
                    end
                end
                SCAN: begin
                    if (!mode) begin
                        state_nxt = IDLE;
                        vld_nxt   = 1'b0;
                        code_nxt  = '0;
                        dwell_nxt = '0;
                    end else if (dwell == DWELL_MAX) begin
                        dwell_nxt = '0;
                        // Using >= here also covers scan_last being lowered below the current code.
                        if (cur_code >= scan_last) begin
                            code_nxt = '0;
                            wrap_nxt = 1'b1;
                        end else begin
                            code_nxt = cur_code + 1'b1;
                        end
                    end else begin
                        dwell_nxt = dwell + 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    vld_nxt   = 1'b0;
                    code_nxt  = '0;
                    dwell_nxt = '0;
                end
            endcase
        end

        out_nxt = vld_nxt ? decode(code_nxt) : '0;
    end

    // Hold the state and all registered outputs; reset clears them asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dwell     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            cur_code  <= '0;
            wrap      <= 1'b0;
        end else begin
            state     <= state_nxt;
            dwell     <= dwell_nxt;
            out       <= out_nxt;
            out_valid <= vld_nxt;
            cur_code  <= code_nxt;
            wrap      <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Testbench for onehot_scan_decoder with SEL_W=4 and DWELL=2.
// A behavioural model tracks which code is shown and how long it has been shown.
module tb_onehot_scan_decoder;

    localparam int SEL_W = 4;
    localparam int DWELL = 2;
    localparam int OUT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             mode;
    logic [SEL_W-1:0] sel;
    logic             sel_valid;
    logic             sel_ready;
    logic [SEL_W-1:0] scan_last;
    logic [OUT_W-1:0] out;
    logic             out_valid;
    logic [SEL_W-1:0] cur_code;
    logic             wrap;

    int npass  = 0;
    int ntotal = 0;

    // Model state: whether a code is live, whether it is scanning, the shown code,
    // how many cycles that code has been shown, and the expected wrap pulse.
    bit m_live, m_scan, m_wrap;
    int m_code, m_age;

    onehot_scan_decoder #(.SEL_W(SEL_W), .DWELL(DWELL)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel),
        .sel_valid(sel_valid), .sel_ready(sel_ready), .scan_last(scan_last),
        .out(out), .out_valid(out_valid), .cur_code(cur_code), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntotal++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] exp_out();
        return m_live ? (32'd1 << (OUT_W - 1 - m_code)) : 32'd0;
    endfunction

    task automatic model_reset();
        m_live = 0; m_scan = 0; m_wrap = 0; m_code = 0; m_age = 0;
    endtask

    // Apply one rising edge to the model, using the inputs currently driven.
    task automatic model_step();
        m_wrap = 0;
        if (!en) begin
            model_reset();
        end else if (mode) begin
            if (!m_scan) begin
                m_scan = 1; m_live = 1; m_code = 0; m_age = 1;
            end else if (m_age == DWELL) begin
                m_age = 1;
                if (m_code >= int'(scan_last)) begin
                    m_code = 0; m_wrap = 1;
                end else begin
                    m_code = m_code + 1;
                end
            end else begin
                m_age = m_age + 1;
            end
        end else if (m_scan) begin
            model_reset();
        end else if (sel_valid) begin
            m_live = 1; m_code = int'(sel);
        end
    endtask

    task automatic check_outputs();
        chk("out", 32'(out), exp_out());
        chk("out_valid", 32'(out_valid), 32'(m_live));
        chk("cur_code", 32'(cur_code), 32'(m_code));
        chk("wrap", 32'(wrap), 32'(m_wrap));
    endtask

    task automatic drive(input bit e, input bit m, input int s, input bit sv, input int sl);
        en = e; mode = m; sel = SEL_W'(s); sel_valid = sv; scan_last = SEL_W'(sl);
    endtask

    // Called at a falling edge with the inputs already set: check sel_ready,
    // advance one clock, then check the registered outputs.
    task automatic step();
        #1;
        chk("sel_ready", 32'(sel_ready), 32'(en && !mode && !m_scan));
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        int seq_code[8];
        int seq_wrap[8];
        int guard;
        seq_code = '{0, 0, 1, 1, 2, 2, 0, 0};
        seq_wrap = '{0, 0, 0, 0, 0, 0, 1, 0};

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // Direct decode of the lowest and highest codes.
        drive(1, 0, 0, 1, 0); step();
        chk("direct0_out", 32'(out), 32'h8000);
        drive(1, 0, 15, 1, 0); step();
        chk("direct15_out", 32'(out), 32'h0001);
        chk("direct15_code", 32'(cur_code), 32'd15);

        // Back-to-back handshakes on consecutive cycles.
        drive(1, 0, 3, 1, 0); step();
        chk("b2b3_out", 32'(out), 32'h1000);
        #1 chk("b2b_ready", 32'(sel_ready), 32'd1);
        drive(1, 0, 4, 1, 0); step();
        chk("b2b4_out", 32'(out), 32'h0800);
        drive(1, 0, 9, 0, 0); step();
        chk("hold_out", 32'(out), 32'h0800);

        // Scan up to code 2 and wrap back to 0.
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 5, 1, 2); step();
            chk("scan_code", 32'(cur_code), 32'(seq_code[i]));
            chk("scan_wrap", 32'(wrap), 32'(seq_wrap[i]));
            chk("scan_ready", 32'(sel_ready), 32'd0);
        end

        // Lower scan_last while code 3 is on display.
        guard = 0;
        while (cur_code != 3 && guard < 20) begin
            drive(1, 1, 0, 0, 3); step(); guard++;
        end
        chk("reach3", 32'(cur_code), 32'd3);
        guard = 0;
        while (cur_code == 3 && guard < 5) begin
            drive(1, 1, 0, 0, 1); step(); guard++;
        end
        chk("lower_code", 32'(cur_code), 32'd0);
        chk("lower_wrap", 32'(wrap), 32'd1);

        // Disable mid-scan, then re-enable.
        drive(0, 1, 0, 0, 3); step();
        chk("dis_out", 32'(out), 32'h0);
        drive(1, 1, 0, 0, 3); step();
        chk("reen_out", 32'(out), 32'h8000);

        // A select offered while leaving scan mode is not accepted.
        drive(1, 0, 7, 1, 3); step();
        chk("scanexit_vld", 32'(out_valid), 32'd0);

        // Scan with scan_last=0 holds code 0 and pulses wrap.
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 0, 0, 0); step();
        end

        // Asynchronous reset while scanning at code 2.
        drive(0, 0, 0, 0, 3); step();
        guard = 0;
        while (cur_code != 2 && guard < 20) begin
            drive(1, 1, 0, 0, 3); step(); guard++;
        end
        chk("reach2", 32'(cur_code), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 1, 0, 0, 3); step();
        chk("rst_restart", 32'(cur_code), 32'd0);
        chk("rst_restart_vld", 32'(out_valid), 32'd1);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            bit e, m, sv;
            int s, sl;
            e  = ($urandom_range(0, 15) != 0);
            m  = ($urandom_range(0, 9) == 0) ? !mode : mode;
            s  = $urandom_range(0, 15);
            sv = $urandom_range(0, 1);
            sl = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 15) : int'(scan_last);
            drive(e, m, s, sv, sl);
            step();
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
